// File: rtl/i2c_oled_streamer_pkg.sv
// Shared types and constants for the SSD1306 I2C streamer.
// Holds the controller state set, control-byte values and the default slave address.
package oled_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK_A,
        ST_CTRL,
        ST_ACK_C,
        ST_DATA,
        ST_ACK_D,
        ST_STOP
    } state_t;

    localparam logic [7:0] CTRL_CMD         = 8'h00;
    localparam logic [7:0] CTRL_DATA        = 8'h40;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h3C;

    function automatic logic is_ack_state(input state_t s);
        return (s == ST_ACK_A) || (s == ST_ACK_C) || (s == ST_ACK_D);
    endfunction

endpackage

// File: rtl/i2c_oled_streamer_tick_gen.sv
// Quarter-bit tick generator: one tick every DIV clocks while enabled.
// Freeze holds the count so a stalled transfer resumes with a full quarter period.
module i2c_tick_gen
    import oled_i2c_pkg::*;
#(
    parameter int unsigned DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic freeze,
    output logic tick
);

    logic [11:0] cnt;

    assign tick = en && !freeze && (cnt == 12'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= tick ? '0 : cnt + 12'd1;
        end
    end

endmodule

// File: rtl/i2c_oled_streamer.sv
// Write-only I2C master streaming a control byte plus payload to an SSD1306.
// Open-drain bus: lines are only ever pulled low or released.
module i2c_oled_streamer
    import oled_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int unsigned DIV      = 125,
    parameter int unsigned LEN_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             data_mode,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic [LEN_W-1:0] byte_cnt,
    inout  wire              sda,
    inout  wire              scl
);

    state_t           state, state_d;
    logic [1:0]       quarter, quarter_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shreg, sh_d;
    logic             sda_oe, sda_oe_d;
    logic             scl_oe, scl_oe_d;
    logic             wait_byte, wait_d;
    logic             ack_ok, ack_d;
    logic             nack_d, done_d;
    logic [LEN_W-1:0] cnt_d, cnt_inc, len_r, len_d;
    logic [7:0]       ctrl_r, ctrl_d;
    logic             sda_s1, sda_s2;
    logic             tick;

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign scl     = scl_oe ? 1'b0 : 1'bz;
    assign busy    = (state != ST_IDLE);
    assign cnt_inc = byte_cnt + LEN_W'(1);

    i2c_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (busy),
        .freeze (wait_byte),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            quarter   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            wait_byte <= 1'b0;
            ack_ok    <= 1'b0;
            nack      <= 1'b0;
            byte_cnt  <= '0;
            done      <= 1'b0;
            len_r     <= '0;
            ctrl_r    <= '0;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
        end else begin
            state     <= state_d;
            quarter   <= quarter_d;
            bit_idx   <= bit_d;
            shreg     <= sh_d;
            sda_oe    <= sda_oe_d;
            scl_oe    <= scl_oe_d;
            wait_byte <= wait_d;
            ack_ok    <= ack_d;
            nack      <= nack_d;
            byte_cnt  <= cnt_d;
            done      <= done_d;
            len_r     <= len_d;
            ctrl_r    <= ctrl_d;
            sda_s1    <= sda;
            sda_s2    <= sda_s1;
        end
    end

    always_comb begin
        state_d   = state;
        quarter_d = quarter;
        bit_d     = bit_idx;
        sh_d      = shreg;
        sda_oe_d  = sda_oe;
        scl_oe_d  = scl_oe;
        wait_d    = wait_byte;
        ack_d     = ack_ok;
        nack_d    = nack;
        cnt_d     = byte_cnt;
        done_d    = 1'b0;
        len_d     = len_r;
        ctrl_d    = ctrl_r;
        tx_ready  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                sda_oe_d  = 1'b0;
                scl_oe_d  = 1'b0;
                quarter_d = '0;
                wait_d    = 1'b0;
                // done is high on the first idle cycle, so a coincident start is dropped
                if (start && !done) begin
                    state_d = ST_START;
                    len_d   = len;
                    ctrl_d  = data_mode ? CTRL_DATA : CTRL_CMD;
                    nack_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    quarter_d = quarter + 2'd1;
                    if (quarter == 2'd0) sda_oe_d = 1'b1;
                    if (quarter == 2'd2) begin
                        scl_oe_d  = 1'b1;
                        state_d   = ST_ADDR;
                        quarter_d = '0;
                        bit_d     = 3'd7;
                        sh_d      = {DEV_ADDR, 1'b0};
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    quarter_d = quarter + 2'd1;
                    if (quarter == 2'd0) sda_oe_d = 1'b1;
                    if (quarter == 2'd1) scl_oe_d = 1'b0;
                    if (quarter == 2'd2) begin
                        sda_oe_d  = 1'b0;
                        state_d   = ST_IDLE;
                        quarter_d = '0;
                        done_d    = 1'b1;
                    end
                end
            end

            default: begin
                // wait_byte parks the bus with SCL low until the next payload byte arrives
                if (wait_byte) begin
                    if (tx_valid) begin
                        tx_ready  = 1'b1;
                        sh_d      = tx_data;
                        bit_d     = 3'd7;
                        wait_d    = 1'b0;
                        quarter_d = '0;
                        state_d   = ST_DATA;
                    end
                end else if (tick) begin
                    quarter_d = quarter + 2'd1;
                    unique case (quarter)
                        2'd0: sda_oe_d = is_ack_state(state) ? 1'b0 : ~shreg[7];
                        2'd1: scl_oe_d = 1'b0;
                        2'd2: if (is_ack_state(state)) ack_d = ~sda_s2;
                        2'd3: begin
                            scl_oe_d = 1'b1;
                            unique case (state)
                                ST_ADDR, ST_CTRL, ST_DATA: begin
                                    if (bit_idx != 3'd0) begin
                                        bit_d = bit_idx - 3'd1;
                                        sh_d  = {shreg[6:0], 1'b0};
                                    end else if (state == ST_ADDR) begin
                                        state_d = ST_ACK_A;
                                    end else if (state == ST_CTRL) begin
                                        state_d = ST_ACK_C;
                                    end else begin
                                        state_d = ST_ACK_D;
                                    end
                                end
                                ST_ACK_A: begin
                                    if (!ack_ok) begin
                                        nack_d  = 1'b1;
                                        state_d = ST_STOP;
                                    end else begin
                                        state_d = ST_CTRL;
                                        sh_d    = ctrl_r;
                                        bit_d   = 3'd7;
                                    end
                                end
                                ST_ACK_C: begin
                                    if (!ack_ok) begin
                                        nack_d  = 1'b1;
                                        state_d = ST_STOP;
                                    end else if (len_r == '0) begin
                                        state_d = ST_STOP;
                                    end else begin
                                        wait_d = 1'b1;
                                    end
                                end
                                ST_ACK_D: begin
                                    if (!ack_ok) begin
                                        nack_d  = 1'b1;
                                        state_d = ST_STOP;
                                    end else begin
                                        cnt_d = cnt_inc;
                                        if (cnt_inc == len_r) state_d = ST_STOP;
                                        else                  wait_d  = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_oled_streamer.sv
// Randomised scoreboard bench for i2c_oled_streamer with an I2C slave/bus decoder model.
// Expected bus bytes and counts come from a transaction-level model of the protocol rules.
module tb_i2c_oled_streamer;

    localparam int unsigned DIV   = 4;
    localparam int unsigned LEN_W = 10;
    localparam int EV_STOP  = 256;
    localparam int EV_START = 257;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             data_mode = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_valid = 1'b0;
    logic             tx_ready, busy, done, nack;
    logic [LEN_W-1:0] byte_cnt;
    wire              sda, scl;
    logic             slave_low = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_oled_streamer #(.DEV_ADDR(7'h3C), .DIV(DIV), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_mode (data_mode),
        .len       (len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .nack      (nack),
        .byte_cnt  (byte_cnt),
        .sda       (sda),
        .scl       (scl)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    logic [7:0] tx_q[$];
    int         gap_q[$];
    logic [7:0] pl_q[$];
    bit         ack_plan[0:31];
    int         tx_seen = 0;
    int         done_seen = 0;
    int         drv_taken = 0;
    bit         hold_after = 1'b0;
    bit         mon_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_event(input string name, input int act);
        int e;
        e = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        check(name, act, e);
    endtask

    // Payload source: presents the head of tx_q, honouring per-byte gaps and the stall hold.
    initial begin : driver
        bit took;
        bit armed;
        int gap_left;
        armed = 1'b0;
        gap_left = 0;
        forever begin
            @(negedge clk);
            took = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            if (took && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                drv_taken++;
                armed = 1'b0;
            end
            if (tx_q.size() == 0) begin
                tx_valid = 1'b0;
                armed = 1'b0;
            end else if (hold_after && drv_taken >= 1) begin
                tx_valid = 1'b0;
            end else begin
                if (!armed) begin
                    armed = 1'b1;
                    gap_left = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
                end
                if (gap_left > 0) begin
                    gap_left--;
                    tx_valid = 1'b0;
                end else begin
                    tx_valid = 1'b1;
                    tx_data = tx_q[0];
                end
            end
        end
    end

    // Bus monitor and slave: decodes START/bytes/STOP and answers ACK per ack_plan.
    always @(negedge clk) begin : monitor
        bit c, s;
        static bit prev_scl = 1'b1;
        static bit prev_sda = 1'b1;
        static int bit_cnt = 0;
        static int byte_idx = 0;
        static logic [7:0] shift = 8'h00;
        if (!rst_n) begin
            prev_scl = 1'b1;
            prev_sda = 1'b1;
            bit_cnt = 0;
            byte_idx = 0;
            slave_low = 1'b0;
        end else begin
            c = (scl !== 1'b0);
            s = (sda !== 1'b0);
            if (tx_ready) begin
                tx_seen++;
                check("tx_ready_needs_valid", int'(tx_valid), 1);
            end
            if (done) begin
                done_seen++;
                check("busy_low_at_done", int'(busy), 0);
            end
            if (prev_scl && c && prev_sda && !s) begin
                if (mon_en) expect_event("bus_start", EV_START);
                bit_cnt = 0;
                byte_idx = 0;
            end else if (prev_scl && c && !prev_sda && s) begin
                if (mon_en) expect_event("bus_stop", EV_STOP);
                bit_cnt = 0;
                slave_low = 1'b0;
            end else if (!prev_scl && c) begin
                if (bit_cnt < 8) begin
                    shift = {shift[6:0], s};
                    bit_cnt++;
                    if (bit_cnt == 8 && mon_en) expect_event("bus_byte", int'(shift));
                end else if (bit_cnt == 8) begin
                    bit_cnt = 9;
                    byte_idx++;
                end
            end else if (prev_scl && !c) begin
                if (bit_cnt == 8) begin
                    slave_low = (byte_idx < 32) ? ack_plan[byte_idx] : 1'b0;
                end else if (bit_cnt == 9) begin
                    slave_low = 1'b0;
                    bit_cnt = 0;
                end
            end
            prev_scl = c;
            prev_sda = s;
        end
    end

    task automatic issue_start(input bit dm, input int n);
        @(negedge clk);
        data_mode = dm;
        len = LEN_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // nack_at: bus byte index the slave refuses (0 address, 1 control, 2+k payload k), -1 none.
    task automatic run_txn(input bit dm, input int n, input int nack_at, input int gap_max,
                           input bit stall, input bit restart);
        int sent, acked, nk, d0, t0, waited, lows;
        for (int i = 0; i < 32; i++) ack_plan[i] = (i != nack_at);
        sent = 0;
        acked = 0;
        nk = 0;
        exp_q.push_back(EV_START);
        exp_q.push_back('h78);
        if (nack_at == 0) begin
            nk = 1;
        end else begin
            exp_q.push_back(dm ? 'h40 : 'h00);
            if (nack_at == 1) begin
                nk = 1;
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back(int'(pl_q[k]));
                    sent++;
                    if (nack_at == k + 2) begin
                        nk = 1;
                        break;
                    end
                    acked++;
                end
            end
        end
        exp_q.push_back(EV_STOP);
        for (int k = 0; k < n; k++) begin
            tx_q.push_back(pl_q[k]);
            gap_q.push_back((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        hold_after = stall;
        drv_taken = 0;
        d0 = done_seen;
        t0 = tx_seen;
        issue_start(dm, n);
        if (stall) begin
            waited = 0;
            while (int'(byte_cnt) != 1 && waited < 4000) begin
                @(negedge clk);
                waited++;
            end
            check("stall_reached_first_ack", int'(byte_cnt), 1);
            lows = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (scl === 1'b0) lows++;
            end
            check("stall_scl_low_cycles", lows, 50);
            hold_after = 1'b0;
        end
        if (restart) begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (done_seen == d0 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        repeat (30) @(negedge clk);
        check("done_pulses", done_seen - d0, 1);
        check("tx_ready_pulses", tx_seen - t0, sent);
        check("byte_cnt", int'(byte_cnt), acked);
        check("nack", int'(nack), nk);
        check("busy_after_done", int'(busy), 0);
        check("bus_events_left", exp_q.size(), 0);
        tx_q.delete();
        gap_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_abort_test();
        int waited, t0, d0;
        mon_en = 1'b0;
        for (int i = 0; i < 32; i++) ack_plan[i] = 1'b1;
        tx_q = '{8'h12, 8'h34, 8'h56};
        gap_q = '{0, 0, 0};
        hold_after = 1'b0;
        drv_taken = 0;
        t0 = tx_seen;
        d0 = done_seen;
        issue_start(1'b1, 3);
        waited = 0;
        while (tx_seen == t0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("abort_first_load", tx_seen - t0, 1);
        repeat (58) @(negedge clk);
        check("abort_busy_before_reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sda_released", int'(sda === 1'b1), 1);
        check("abort_scl_released", int'(scl === 1'b1), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_tx_ready", int'(tx_ready), 0);
        check("abort_nack", int'(nack), 0);
        check("abort_byte_cnt", int'(byte_cnt), 0);
        tx_q.delete();
        gap_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_stays_idle", int'(busy), 0);
        mon_en = 1'b1;
    endtask

    initial begin : main
        int n, nk;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tx_ready", int'(tx_ready), 0);
        check("rst_nack", int'(nack), 0);
        check("rst_byte_cnt", int'(byte_cnt), 0);
        check("rst_sda", int'(sda === 1'b1), 1);
        check("rst_scl", int'(scl === 1'b1), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pl_q = '{8'hAE, 8'hAF};
        run_txn(1'b0, 2, -1, 0, 1'b0, 1'b0);

        pl_q.delete();
        run_txn(1'b1, 0, -1, 0, 1'b0, 1'b0);

        pl_q = '{8'h11, 8'h22};
        run_txn(1'b0, 2, 0, 0, 1'b0, 1'b0);

        pl_q = '{8'h5A, 8'hC3, 8'h0F};
        run_txn(1'b1, 3, -1, 0, 1'b1, 1'b0);

        reset_abort_test();

        pl_q = '{8'h81};
        run_txn(1'b0, 1, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            n = int'($urandom_range(0, 5));
            pl_q.delete();
            for (int k = 0; k < n; k++) pl_q.push_back(8'($urandom_range(0, 255)));
            nk = ($urandom_range(0, 9) < 7) ? -1 : int'($urandom_range(0, n + 1));
            run_txn(1'($urandom_range(0, 1)), n, nk, 12, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
